// File: rtl/nexus_dsp_pkg.sv
// Shared constants and arithmetic helpers for the Nexus DSP accumulation path.
// sat_add is only referenced when MULT9X9_ACCUM_SAT_EN is defined.
package nexus_dsp_pkg;

  localparam int MULT9X9_Z_W = 18;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic signed [63:0] sum;
    logic               ovf;
  } sat_res_t;

  // Sign-extend the low w bits of v to 64 bits.
  function automatic logic signed [63:0] sext(input logic [63:0] v, input int w);
    logic signed [63:0] t;
    t = signed'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  // Add two in-range w-bit values and clamp the result to the signed w-bit range.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int w);
    logic signed [63:0] s, hi, lo;
    sat_res_t r;
    s = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    r.sum = s;
    r.ovf = 1'b0;
    if (s > hi) begin
      r.sum = hi;
      r.ovf = 1'b1;
    end else if (s < lo) begin
      r.sum = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult9x9_accum_if.sv
// Product-in / frame-sum-out handshake bundle for mult9x9_accum.
interface mult9x9_accum_if #(
  parameter int Z_W   = 18,
  parameter int ACC_W = 24
);
  logic [Z_W-1:0]   Z;
  logic             Z_VALID;
  logic             Z_READY;
  logic             CLR;
  logic [ACC_W-1:0] ACC;
  logic             ACC_VALID;
  logic             ACC_READY;
  logic             ACC_OVF;

  modport slave  (input  Z, Z_VALID, CLR, ACC_READY,
                  output Z_READY, ACC, ACC_VALID, ACC_OVF);
  modport master (output Z, Z_VALID, CLR, ACC_READY,
                  input  Z_READY, ACC, ACC_VALID, ACC_OVF);
endinterface

// File: rtl/dsp_acc_fifo2.sv
// Two-entry result buffer; entry 0 is always the head. Push and pop may coincide.
//   state     | meaning
//   BUF_EMPTY | no entries, head invalid
//   BUF_ONE   | ent0 valid
//   BUF_FULL  | ent0 and ent1 valid
module dsp_acc_fifo2
  import nexus_dsp_pkg::*;
#(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         head_valid,
  output logic         full
);

  buf_state_t   state, state_nxt;
  logic [W-1:0] ent0, ent1;
  logic         do_push, do_pop;

  assign do_pop  = pop && (state != BUF_EMPTY);
  assign do_push = push && ((state != BUF_FULL) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BUF_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BUF_EMPTY: if (do_push) state_nxt = BUF_ONE;
      BUF_ONE: begin
        if (do_push && !do_pop)      state_nxt = BUF_FULL;
        else if (do_pop && !do_push) state_nxt = BUF_EMPTY;
      end
      BUF_FULL:  if (do_pop && !do_push) state_nxt = BUF_ONE;
      default:   state_nxt = BUF_EMPTY;
    endcase
  end

  always_comb begin
    head_valid = (state != BUF_EMPTY);
    full       = (state == BUF_FULL);
    head       = ent0;
  end

  // Pop shifts ent1 forward; a push in the same cycle lands in the slot left free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      if (do_pop) ent0 <= ent1;
      if (do_push) begin
        if (state == BUF_EMPTY || (state == BUF_ONE && do_pop)) ent0 <= push_data;
        else                                                    ent1 <= push_data;
      end
    end
  end

endmodule

// File: rtl/mult9x9_accum.sv
// Frame accumulator behind a MULT9X9 (REGOUTPUT=BYPASS): captures products, sums FRAME_LEN per frame.
// Optional macro MULT9X9_ACCUM_SAT_EN enables saturating adds and the ACC_OVF flag.
module mult9x9_accum
  import nexus_dsp_pkg::*;
#(
  parameter int Z_W       = MULT9X9_Z_W,
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 4
) (
  input logic              CLK,
  input logic              RSTN,
  mult9x9_accum_if.slave   bus
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [Z_W-1:0]   zr;
  logic             zr_v, zr_last, zr_first;
  logic [CNT_W-1:0] term_cnt;
  logic             last_term;
  logic [ACC_W-1:0] acc, sum;
  logic             accept, advance, push, pop, stall;
  logic             buf_valid, buf_full;

  assign last_term   = (term_cnt == CNT_W'(FRAME_LEN - 1));
  assign pop         = buf_valid && bus.ACC_READY;
  assign stall       = zr_v && zr_last && buf_full && !pop;
  assign bus.Z_READY = !stall && !bus.CLR;
  assign accept      = bus.Z_VALID && bus.Z_READY;
  assign advance     = zr_v && !stall && !bus.CLR;
  assign push        = advance && zr_last;

  // zr only ever loads Z so it can be packed into the multiplier's output register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      zr       <= '0;
      zr_v     <= 1'b0;
      zr_last  <= 1'b0;
      zr_first <= 1'b0;
      term_cnt <= '0;
    end else if (bus.CLR) begin
      zr_v     <= 1'b0;
      term_cnt <= '0;
    end else if (accept) begin
      zr       <= bus.Z;
      zr_v     <= 1'b1;
      zr_last  <= last_term;
      zr_first <= (term_cnt == '0);
      term_cnt <= last_term ? '0 : term_cnt + CNT_W'(1);
    end else if (advance) begin
      zr_v     <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)        acc <= '0;
    else if (bus.CLR) acc <= '0;
    else if (advance) acc <= zr_last ? '0 : sum;
  end

`ifdef MULT9X9_ACCUM_SAT_EN
  localparam int D_W = ACC_W + 1;
  sat_res_t res;
  logic     ovf_frame, push_ovf;
  logic [D_W-1:0] head;

  assign res      = sat_add(zr_first ? 64'sd0 : sext(64'(acc), ACC_W),
                            sext(64'(zr), Z_W), ACC_W);
  assign sum      = res.sum[ACC_W-1:0];
  assign push_ovf = ovf_frame | res.ovf;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)        ovf_frame <= 1'b0;
    else if (bus.CLR) ovf_frame <= 1'b0;
    else if (advance) ovf_frame <= zr_last ? 1'b0 : push_ovf;
  end

  dsp_acc_fifo2 #(.W(D_W)) u_fifo (
    .clk        (CLK),
    .rst_n      (RSTN),
    .push       (push),
    .push_data  ({push_ovf, sum}),
    .pop        (pop),
    .head       (head),
    .head_valid (buf_valid),
    .full       (buf_full)
  );

  assign bus.ACC     = head[ACC_W-1:0];
  assign bus.ACC_OVF = head[ACC_W];
`else
  logic [ACC_W-1:0] head;

  // Wraps modulo 2^ACC_W; the size cast sign-extends the product.
  assign sum = (zr_first ? '0 : acc) + ACC_W'(signed'(zr));

  dsp_acc_fifo2 #(.W(ACC_W)) u_fifo (
    .clk        (CLK),
    .rst_n      (RSTN),
    .push       (push),
    .push_data  (sum),
    .pop        (pop),
    .head       (head),
    .head_valid (buf_valid),
    .full       (buf_full)
  );

  assign bus.ACC     = head;
  assign bus.ACC_OVF = 1'b0;
`endif

  assign bus.ACC_VALID = buf_valid;

endmodule

// File: tb/tb_mult9x9_accum.sv
// Scoreboard bench for mult9x9_accum: three instances (24b/4-term, 19b/4-term, 24b/1-term).
// Honors MULT9X9_ACCUM_SAT_EN for the overflow case.
module tb_mult9x9_accum;

  typedef struct {
    longint acc;
    bit     ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  exp_t   q_a[$];
  exp_t   q_b[$];
  exp_t   q_c[$];
  int     c_cyc[$];

  mult9x9_accum_if #(.Z_W(18), .ACC_W(24)) bus_a ();
  mult9x9_accum_if #(.Z_W(18), .ACC_W(19)) bus_b ();
  mult9x9_accum_if #(.Z_W(18), .ACC_W(24)) bus_c ();

  mult9x9_accum #(.Z_W(18), .ACC_W(24), .FRAME_LEN(4)) dut_a (.CLK(clk), .RSTN(rst_n), .bus(bus_a.slave));
  mult9x9_accum #(.Z_W(18), .ACC_W(19), .FRAME_LEN(4)) dut_b (.CLK(clk), .RSTN(rst_n), .bus(bus_b.slave));
  mult9x9_accum #(.Z_W(18), .ACC_W(24), .FRAME_LEN(1)) dut_c (.CLK(clk), .RSTN(rst_n), .bus(bus_c.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int sel, input longint acc, input bit ovf);
    exp_t e;
    e.acc = acc;
    e.ovf = ovf;
    case (sel)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic drive(input int sel, input bit vld, input longint v);
    case (sel)
      0:       begin bus_a.Z_VALID = vld; bus_a.Z = 18'(v); end
      1:       begin bus_b.Z_VALID = vld; bus_b.Z = 18'(v); end
      default: begin bus_c.Z_VALID = vld; bus_c.Z = 18'(v); end
    endcase
  endtask

  function automatic bit ready_of(input int sel);
    case (sel)
      0:       return bus_a.Z_READY;
      1:       return bus_b.Z_READY;
      default: return bus_c.Z_READY;
    endcase
  endfunction

  // Called at negedge+1; returns at negedge+1 after the accepting edge.
  task automatic send(input int sel, input longint v);
    bit rdy = 1'b0;
    int n = 0;
    drive(sel, 1'b1, v);
    while (!rdy && n < 200) begin
      #3;
      rdy = ready_of(sel);
      @(negedge clk);
      #1;
      n++;
    end
    drive(sel, 1'b0, 0);
    if (!rdy) check_val("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Monitors sample just before the rising edge, where a pop takes effect.
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (rst_n === 1'b1 && bus_a.ACC_VALID && bus_a.ACC_READY) begin
      if (q_a.size() == 0) check_val("a_unexpected_result", longint'(signed'(bus_a.ACC)), -999999);
      else begin
        e = q_a.pop_front();
        check_val("a_acc", longint'(signed'(bus_a.ACC)), e.acc);
        check_val("a_ovf", longint'(bus_a.ACC_OVF), longint'(e.ovf));
      end
    end
    if (rst_n === 1'b1 && bus_b.ACC_VALID && bus_b.ACC_READY) begin
      if (q_b.size() == 0) check_val("b_unexpected_result", longint'(signed'(bus_b.ACC)), -999999);
      else begin
        e = q_b.pop_front();
        check_val("b_acc", longint'(signed'(bus_b.ACC)), e.acc);
        check_val("b_ovf", longint'(bus_b.ACC_OVF), longint'(e.ovf));
      end
    end
    if (rst_n === 1'b1 && bus_c.ACC_VALID && bus_c.ACC_READY) begin
      c_cyc.push_back(cyc);
      if (q_c.size() == 0) check_val("c_unexpected_result", longint'(signed'(bus_c.ACC)), -999999);
      else begin
        e = q_c.pop_front();
        check_val("c_acc", longint'(signed'(bus_c.ACC)), e.acc);
        check_val("c_ovf", longint'(bus_c.ACC_OVF), longint'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    longint s;
    longint v;
    rst_n = 1'b0;
    bus_a.CLR = 1'b0; bus_b.CLR = 1'b0; bus_c.CLR = 1'b0;
    bus_a.ACC_READY = 1'b1; bus_b.ACC_READY = 1'b1; bus_c.ACC_READY = 1'b1;
    drive(0, 1'b0, 0); drive(1, 1'b0, 0); drive(2, 1'b0, 0);
    #2;
    check_val("rst_acc_valid", longint'(bus_a.ACC_VALID), 0);
    check_val("rst_acc", longint'(bus_a.ACC), 0);
    check_val("rst_acc_ovf", longint'(bus_a.ACC_OVF), 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_val("rst_z_ready", longint'(bus_a.Z_READY), 1);
    idle(1);

    // Basic frame and latency
    push_exp(0, 60, 1'b0);
    send(0, 100); send(0, -50); send(0, 7); send(0, 3);
    check_val("lat_not_yet", longint'(bus_a.ACC_VALID), 0);
    idle(1);
    check_val("lat_valid", longint'(bus_a.ACC_VALID), 1);
    idle(1);
    check_val("valid_one_cycle", longint'(bus_a.ACC_VALID), 0);

    // Backpressure: two buffered, third frame's last term stalls
    bus_a.ACC_READY = 1'b0;
    repeat (3) push_exp(0, 4, 1'b0);
    repeat (12) send(0, 1);
    check_val("stall_z_ready", longint'(bus_a.Z_READY), 0);
    idle(2);
    check_val("stall_held", longint'(bus_a.Z_READY), 0);
    check_val("stall_buffered", longint'(q_a.size()), 3);
    bus_a.ACC_READY = 1'b1;
    #1;
    check_val("zready_same_cycle", longint'(bus_a.Z_READY), 1);
    idle(6);
    check_val("stall_drained", longint'(q_a.size()), 0);

    // Randomized frames
    for (int f = 0; f < 3; f++) begin
      s = 0;
      for (int t = 0; t < 4; t++) begin
        v = longint'($urandom_range(2000)) - 1000;
        s += v;
        if (t == 0) push_exp(0, 0, 1'b0);
        q_a[q_a.size()-1].acc = s;
        send(0, v);
      end
    end
    idle(4);
    check_val("rand_drained", longint'(q_a.size()), 0);

    // Frame abort
    send(0, 10); send(0, 20);
    bus_a.CLR = 1'b1;
    drive(0, 1'b1, 99);
    #1;
    check_val("clr_blocks_ready", longint'(bus_a.Z_READY), 0);
    @(negedge clk);
    #1;
    bus_a.CLR = 1'b0;
    drive(0, 1'b0, 0);
    push_exp(0, 10, 1'b0);
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    idle(4);
    check_val("clr_drained", longint'(q_a.size()), 0);

    // Overflow on the 19-bit instance
`ifdef MULT9X9_ACCUM_SAT_EN
    push_exp(1, 262143, 1'b1);
`else
    push_exp(1, -4, 1'b0);
`endif
    repeat (4) send(1, 131071);
    idle(4);
    check_val("ovf_drained", longint'(q_b.size()), 0);

    // Single-term frames, back to back
    push_exp(2, -5, 1'b0);
    push_exp(2, 9, 1'b0);
    send(2, -5); send(2, 9);
    idle(4);
    check_val("c_drained", longint'(q_c.size()), 0);
    check_val("c_back_to_back", (c_cyc.size() == 2) ? longint'(c_cyc[1] - c_cyc[0]) : -1, 1);

    // Reset mid-frame with a result buffered
    bus_a.ACC_READY = 1'b0;
    push_exp(0, 4, 1'b0);
    repeat (6) send(0, 1);
    check_val("pre_rst_valid", longint'(bus_a.ACC_VALID), 1);
    rst_n = 1'b0;
    #1;
    check_val("rst_clears_valid", longint'(bus_a.ACC_VALID), 0);
    q_a.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_val("post_rst_z_ready", longint'(bus_a.Z_READY), 1);
    bus_a.ACC_READY = 1'b1;
    idle(1);
    push_exp(0, 20, 1'b0);
    repeat (4) send(0, 5);
    idle(4);
    check_val("post_rst_drained", longint'(q_a.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
